// File: rtl/cla_seq_adder.sv
// Sequential adder/subtractor: one 4-bit carry-lookahead slice is reused once per nibble,
// least significant first, under a valid/ready handshake with abort.
module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;

    logic [3:0] nib_a, nib_b, g, p, slice_sum;
    logic [3:0] c;
    logic       c4;

    // Lookahead slice: every carry is expressed directly from g, p and the incoming carry.
    always_comb begin
        nib_a = a_q[{cnt_q, 2'b00} +: 4];
        nib_b = b_q[{cnt_q, 2'b00} +: 4];
        g     = nib_a & nib_b;
        p     = nib_a ^ nib_b;
        c[0]  = carry_q;
        c[1]  = g[0] | (p[0] & carry_q);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
        c4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carry_q);
        slice_sum = p ^ c;
    end

    always_comb begin
        // NOTE: every next-state variable takes its hold value first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    sum_d   = '0;
                end else begin
                    sum_d[{cnt_q, 2'b00} +: 4] = slice_sum;
                    carry_d = c4;
                    if (cnt_q == LAST_NIB) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // Abort takes priority over a simultaneous delivery; both leave a clean IDLE.
                if (abort || out_ready) begin
                    state_d = IDLE;
                    carry_d = 1'b0;
                    sum_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                carry_d = 1'b0;
                sum_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = out_valid & carry_q;
    // b_q already holds ~b for subtraction, so one formula covers both operations.
    assign overflow  = out_valid & (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder (WIDTH = 16): expected results are queued at issue
// and compared when out_valid appears.
module tb_cla_seq_adder;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             abort = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    cla_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic in signed integers, independent of the nibble datapath.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic sb);
        exp_t        e;
        logic [16:0] full;
        int          r;
        if (sb) begin
            full = {1'b0, x} + {1'b0, ~y} + 17'd1;
            r    = int'($signed(x)) - int'($signed(y));
        end else begin
            full = {1'b0, x} + {1'b0, y} + {16'd0, ci};
            r    = int'($signed(x)) + int'($signed(y)) + int'(ci);
        end
        e.s = full[15:0];
        e.c = full[16];
        e.o = (r > 32767) || (r < -32768);
        return e;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, input logic sb, input exp_t e);
        check("ready_before_issue", 32'(in_ready), 32'd1);
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic collect(output exp_t e);
        int cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check("latency", 32'(cycles), 32'(NIBBLES));
        e = sb_q.pop_front();
        check("sum", 32'(sum), 32'(e.s));
        check("cout", 32'(cout), 32'(e.c));
        check("overflow", 32'(overflow), 32'(e.o));
    endtask

    task automatic deliver();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_after_deliver", 32'(out_valid), 32'd0);
        check("ready_after_deliver", 32'(in_ready), 32'd1);
        check("sum_idle", {sum, cout, overflow}, 32'd0);
    endtask

    initial begin
        exp_t        e;
        exp_t        held;
        logic [15:0] ra, rb;
        logic        rc, rs;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_outputs", {sum, cout, overflow, out_valid, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        e = '{16'h2233, 1'b0, 1'b0};
        send(16'h1234, 16'h0FFF, 1'b0, 1'b0, e);
        collect(e);
        deliver();

        e = '{16'h0000, 1'b1, 1'b0};
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, e);
        collect(e);
        deliver();

        e = '{16'h8000, 1'b0, 1'b1};
        send(16'h7FFF, 16'h0000, 1'b1, 1'b0, e);
        collect(e);
        deliver();

        // cin is ignored for subtraction.
        e = '{16'hFFFE, 1'b0, 1'b0};
        send(16'h0005, 16'h0007, 1'b1, 1'b1, e);
        collect(e);
        deliver();

        e = '{16'h7FFF, 1'b1, 1'b1};
        send(16'h8000, 16'h0001, 1'b0, 1'b1, e);
        collect(held);

        // Back-pressure with a pending request: outputs hold, request is not taken.
        a = 16'h0102; b = 16'h0304; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_result", {sum, cout, overflow}, {held.s, held.c, held.o});
        end
        sb_q.push_back(model(16'h0102, 16'h0304, 1'b0, 1'b0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("pulse_to_idle", {30'd0, in_ready, out_valid}, 32'h2);
        @(negedge clk);
        in_valid = 1'b0;
        check("accept_after_pulse", 32'(busy), 32'd1);
        collect(e);
        deliver();

        // Reset after the second RUN edge discards the partial result.
        send(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_rst_outputs", {sum, cout, overflow, out_valid, busy}, 32'd0);
        check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        void'(sb_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        send(16'h0001, 16'h0001, 1'b0, 1'b0, '{16'h0002, 1'b0, 1'b0});
        collect(e);
        deliver();

        // Abort during RUN.
        send(16'hABCD, 16'h1234, 1'b0, 1'b0, model(16'hABCD, 16'h1234, 1'b0, 1'b0));
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        void'(sb_q.pop_front());
        check("abort_run_idle", {30'd0, in_ready, busy}, 32'h2);
        check("abort_run_sum", 32'(sum), 32'd0);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                seen = seen | out_valid;
            end
            check("abort_run_no_valid", 32'(seen), 32'd0);
        end

        // Abort together with out_ready in DONE: cleared, not delivered.
        send(16'h4000, 16'h4000, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1});
        collect(e);
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        check("abort_done_outputs", {sum, cout, overflow, out_valid, busy}, 32'd0);

        // Abort in IDLE does not block a simultaneous accept.
        abort = 1'b1;
        send(16'h00F0, 16'h0010, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0});
        abort = 1'b0;
        collect(e);
        deliver();

        // Random operations against the arithmetic model.
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
            collect(e);
            deliver();
        end

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
